// File: rtl/keypad_reader_pkg.sv
// Shared IO definitions for the keypad input peripheral: IO address, FSM states,
// read-word bit positions and the row priority helper.
package keypad_reader_pkg;

    localparam logic [15:0] KEYPAD_IO_ADDR = 16'hFF02;
    localparam int          PENDING_BIT    = 15;
    localparam int          OVERRUN_BIT    = 14;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DEB,
        HELD,
        RELEASE_DEB
    } kp_state_t;

    // Index of the lowest active-low row; only meaningful when some row is low.
    function automatic logic [1:0] lowest_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!rows[r]) idx = 2'(r);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan.sv
// Column scanner: steps one active-low column per SCAN_DIV cycles, samples the
// synchronized rows at each slot end and reports the frame's first hit.
module keypad_scan
    import keypad_reader_pkg::*;
#(
    parameter int SCAN_DIV = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rows,
    output logic [3:0] col_out,
    output logic       frame_end,
    output logic       frame_hit,
    output logic [3:0] frame_code
);

    localparam int                SLOT_W    = $clog2(SCAN_DIV);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

    logic [SLOT_W-1:0] slot;
    logic [1:0]        col;
    logic              hit_q;
    logic [3:0]        code_q;
    logic              slot_end;
    logic              row_low;
    logic [3:0]        sample_code;

    assign slot_end    = (slot == SLOT_LAST);
    assign row_low     = ~&rows;
    assign sample_code = {lowest_row(rows), col};
    assign frame_end   = slot_end && (col == 2'd3);
    assign col_out     = ~(4'b0001 << col);

    // The frame-end sample is folded in combinationally so column 3 counts in this frame.
    assign frame_hit  = hit_q || (slot_end && row_low);
    assign frame_code = hit_q ? code_q : sample_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot   <= '0;
            col    <= 2'd0;
            hit_q  <= 1'b0;
            code_q <= 4'd0;
        end else begin
            slot <= slot_end ? '0 : slot + 1'b1;
            if (slot_end) begin
                col <= col + 2'd1;
                if (col == 2'd3) begin
                    hit_q <= 1'b0;
                end else if (row_low && !hit_q) begin
                    hit_q  <= 1'b1;
                    code_q <= sample_code;
                end
            end
        end
    end

endmodule

// File: rtl/keypad_reader.sv
// 4x4 matrix keypad reader: frame-level debounce FSM, latched key with
// pending/overrun flags, and the 16-bit CPU read word acknowledged by KeyCtrl.
//
// state       | meaning
// IDLE        | no key; waiting for a frame with a hit
// PRESS_DEB   | same code seen cnt frames in a row; accept at DEBOUNCE
// HELD        | key accepted; waiting for an empty frame
// RELEASE_DEB | empty for cnt frames; back to IDLE at DEBOUNCE
module keypad_reader
    import keypad_reader_pkg::*;
#(
    parameter int SCAN_DIV = 4096,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        KeyCtrl,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [15:0] read_data
);

    localparam int               CNT_W    = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    kp_state_t        state;
    kp_state_t        state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       cand;
    logic [3:0]       cand_nx;
    logic [3:0]       key;
    logic             pending;
    logic             overrun;
    logic             accept;
    logic             frame_end;
    logic             frame_hit;
    logic [3:0]       frame_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    keypad_scan #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .rows      (row_sync),
        .col_out   (col_out),
        .frame_end (frame_end),
        .frame_hit (frame_hit),
        .frame_code(frame_code)
    );

    assign cnt_inc = (cnt == CNT_DONE) ? cnt : cnt + 1'b1;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cand_nx  = cand;
        accept   = 1'b0;
        if (frame_end) begin
            case (state)
                IDLE: begin
                    if (frame_hit) begin
                        cand_nx  = frame_code;
                        cnt_nx   = CNT_ONE;
                        state_nx = PRESS_DEB;
                    end
                end
                PRESS_DEB: begin
                    // A different code aborts; it is picked up fresh from IDLE next frame.
                    if (frame_hit && frame_code == cand) begin
                        cnt_nx = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            accept   = 1'b1;
                            state_nx = HELD;
                        end
                    end else begin
                        state_nx = IDLE;
                    end
                end
                HELD: begin
                    if (!frame_hit) begin
                        cnt_nx   = CNT_ONE;
                        state_nx = RELEASE_DEB;
                    end
                end
                RELEASE_DEB: begin
                    if (frame_hit) begin
                        state_nx = HELD;
                    end else begin
                        cnt_nx = cnt_inc;
                        if (cnt_inc == CNT_DONE) state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            cand    <= 4'd0;
            key     <= 4'd0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            cand  <= cand_nx;
            if (accept) begin
                // A read on the accepting cycle consumed the old key, so no overrun.
                key     <= cand;
                pending <= 1'b1;
                overrun <= KeyCtrl ? 1'b0 : (overrun | pending);
            end else if (KeyCtrl) begin
                pending <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        read_data              = '0;
        read_data[PENDING_BIT] = pending;
        read_data[OVERRUN_BIT] = overrun;
        read_data[3:0]         = key;
    end

endmodule

// File: tb/tb_keypad_reader.sv
// Self-checking bench for keypad_reader: a physical keypad model drives the rows,
// and a frame-level reference model predicts the read word every cycle.
module tb_keypad_reader;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        KeyCtrl;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] read_data;

    always #5 clk = ~clk;

    keypad_reader #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .KeyCtrl  (KeyCtrl),
        .row_in   (row_in),
        .col_out  (col_out),
        .read_data(read_data)
    );

    // Pressed-key mask, bit r*4+c; a pressed key shorts row r to column c.
    logic [15:0] mask;
    logic [15:0] next_mask;

    for (genvar r = 0; r < 4; r++) begin : g_keypad
        assign row_in[r] = ~|(mask[r*4 +: 4] & ~col_out);
    end

    int         n_tests = 0;
    int         n_fail  = 0;
    int         ph;
    logic       m_pend;
    logic       m_ovr;
    logic [3:0] m_key;
    logic [3:0] m_cand;
    int         streak;
    int         rel;
    bit         down;
    logic [15:0] seen;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // First pressed key in scan order (columns first, then lowest row); bit 4 = any hit.
    function automatic logic [4:0] scan_result(input logic [15:0] m);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (m[r*4 + c]) return {1'b1, 2'(r), 2'(c)};
        return 5'd0;
    endfunction

    task automatic model_reset();
        m_pend = 1'b0;
        m_ovr  = 1'b0;
        m_key  = 4'd0;
        m_cand = 4'd0;
        streak = 0;
        rel    = 0;
        down   = 1'b0;
        ph     = 0;
    endtask

    task automatic tick(input bit kc, output logic [15:0] rd);
        logic [3:0] exp_col;
        logic [4:0] fr;
        bit         acc;
        @(negedge clk);
        if (ph == 0) mask = next_mask;
        KeyCtrl = kc;
        rd = read_data;
        exp_col = ~(4'b0001 << (ph / SCAN_DIV));
        check_val("read_word", read_data, {m_pend, m_ovr, 10'b0, m_key});
        check_val("col_drive", {12'h0, col_out}, {12'h0, exp_col});
        @(posedge clk);
        #1;
        acc = 1'b0;
        if (ph == FRAME - 1) begin
            fr = scan_result(mask);
            if (!down) begin
                if (streak == 0) begin
                    if (fr[4]) begin
                        streak = 1;
                        m_cand = fr[3:0];
                    end
                end else if (fr[4] && fr[3:0] == m_cand) begin
                    streak++;
                    if (streak == DEBOUNCE) begin
                        acc    = 1'b1;
                        down   = 1'b1;
                        streak = 0;
                        rel    = 0;
                    end
                end else begin
                    streak = 0;
                end
            end else if (!fr[4]) begin
                rel++;
                if (rel == DEBOUNCE) begin
                    down = 1'b0;
                    rel  = 0;
                end
            end else begin
                rel = 0;
            end
        end
        if (acc) begin
            m_key  = m_cand;
            m_ovr  = kc ? 1'b0 : (m_ovr | m_pend);
            m_pend = 1'b1;
        end else if (kc) begin
            m_pend = 1'b0;
            m_ovr  = 1'b0;
        end
        ph = (ph + 1) % FRAME;
    endtask

    task automatic run_frames(input int n);
        logic [15:0] rd;
        int k;
        k = 0;
        while (k < n) begin
            tick(1'b0, rd);
            if (ph == 0) k++;
        end
    endtask

    task automatic finish_frame();
        logic [15:0] rd;
        while (ph != 0) tick(1'b0, rd);
    endtask

    task automatic release_keys();
        finish_frame();
        next_mask = 16'h0;
        run_frames(DEBOUNCE);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        KeyCtrl = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic peek(input string tag, input logic [15:0] exp);
        check_val(tag, read_data, exp);
    endtask

    initial begin
        rst       = 1'b1;
        KeyCtrl   = 1'b0;
        mask      = 16'h0;
        next_mask = 16'h0;
        model_reset();
        repeat (3) @(posedge clk);
        do_reset();
        peek("rst_word", 16'h0000);
        check_val("rst_col", {12'h0, col_out}, 16'h000E);

        // Clean press of row 2 / column 1, then a read and a back-to-back read.
        next_mask = 16'h1 << 9;
        run_frames(2);
        peek("clean_early", 16'h0000);
        run_frames(1);
        peek("clean_accept", 16'h8009);
        tick(1'b1, seen);
        check_val("clean_read", seen, 16'h8009);
        tick(1'b1, seen);
        check_val("clean_b2b", seen, 16'h0009);
        peek("clean_ack", 16'h0009);

        // Bounce: 2 frames present, 1 absent, 3 present.
        release_keys();
        next_mask = 16'h1 << 9;
        run_frames(2);
        next_mask = 16'h0;
        run_frames(1);
        next_mask = 16'h1 << 9;
        run_frames(2);
        peek("bounce_early", 16'h0009);
        run_frames(1);
        peek("bounce_accept", 16'h8009);
        run_frames(3);
        peek("bounce_norepeat", 16'h8009);

        // Overrun: key 9 unread, then row 0 / column 3.
        release_keys();
        next_mask = 16'h1 << 3;
        run_frames(DEBOUNCE);
        peek("ovr_accept", 16'hC003);
        tick(1'b1, seen);
        check_val("ovr_read", seen, 16'hC003);
        peek("ovr_ack", 16'h0003);

        // Rows 1 and 3 on column 0: lowest row wins.
        release_keys();
        next_mask = (16'h1 << 4) | (16'h1 << 12);
        run_frames(DEBOUNCE);
        peek("multi_accept", 16'h8004);
        tick(1'b1, seen);
        check_val("multi_read", seen, 16'h8004);
        peek("multi_ack", 16'h0004);

        // Read lands on the accepting frame-end cycle.
        release_keys();
        next_mask = 16'h1 << 9;
        run_frames(DEBOUNCE);
        peek("simul_pre", 16'h8009);
        next_mask = 16'h0;
        run_frames(DEBOUNCE);
        next_mask = 16'h1 << 4;
        run_frames(DEBOUNCE - 1);
        repeat (FRAME - 1) tick(1'b0, seen);
        tick(1'b1, seen);
        check_val("simul_read", seen, 16'h8009);
        peek("simul_after", 16'h8004);

        // Reset during press debounce with cnt=2.
        release_keys();
        next_mask = 16'h1 << 9;
        run_frames(2);
        repeat (5) tick(1'b0, seen);
        do_reset();
        peek("rstmid_word", 16'h0000);
        check_val("rstmid_col", {12'h0, col_out}, 16'h000E);
        run_frames(DEBOUNCE - 1);
        peek("rstmid_early", 16'h0000);
        run_frames(1);
        peek("rstmid_accept", 16'h8009);

        // Random key patterns, random reads, occasional resets.
        finish_frame();
        for (int f = 0; f < 80; f++) begin
            int sel;
            int hold;
            sel = $urandom_range(0, 9);
            if (sel <= 3)      next_mask = 16'h0;
            else if (sel <= 7) next_mask = 16'h1 << $urandom_range(0, 15);
            else if (sel == 8) next_mask = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            hold = $urandom_range(1, 5);
            repeat (hold) begin
                do begin
                    bit kc;
                    if (ph == FRAME - 1) kc = ($urandom_range(0, 3) == 0);
                    else                 kc = ($urandom_range(0, 19) == 0);
                    if ($urandom_range(0, 299) == 0) do_reset();
                    else tick(kc, seen);
                end while (ph != 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
